video_frame_loader: RTL and testbench

Upstream feeder for `led_panel_video`. It accepts a streamed RGB pixel frame over a valid/ready handshake and stores it in a ping-pong frame buffer. It exposes a 1-cycle-latency read port that the panel scanner uses to fetch pixels. Bank swaps happen only at the scanner's end-of-refresh pulse, so a displayed frame never tears.

---
 rtl/video_frame_loader_if.sv | 10 +
 rtl/video_frame_loader.sv | 109 ++++++++++
 tb/tb_video_frame_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/video_frame_loader_if.sv
// Pixel stream handshake into video_frame_loader (valid/ready with start-of-frame).
interface video_frame_loader_if #(parameter int PIX_W = 12);
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             s_sof;

    modport master (output s_valid, s_data, s_sof, input s_ready);
    modport slave  (input s_valid, s_data, s_sof, output s_ready);
endinterface

// File: rtl/video_frame_loader.sv
// Streams an RGB frame into a frame buffer and serves a 1-cycle read port to the panel scanner.
// VIDEO_DOUBLE_BUF_EN: ping-pong banks swapped on frame_sync; undefined gives a single tearing bank.
module video_frame_loader #(
    parameter int H_RES  = 64,
    parameter int V_RES  = 64,
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    video_frame_loader_if.slave  s,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [PIX_W-1:0]     rd_data,
    input  logic                 frame_sync,
    output logic                 frame_ready,
    output logic                 sof_err
);
    localparam int                NPIX      = H_RES * V_RES;
    localparam logic [ADDR_W:0]   NPIX_W    = (ADDR_W + 1)'(NPIX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

`ifdef VIDEO_DOUBLE_BUF_EN
    typedef enum logic [1:0] {WAIT_SOF, WRITE, FULL} state_t;
    localparam int MEM_AW = ADDR_W + 1;
`else
    typedef enum logic [1:0] {WAIT_SOF, WRITE} state_t;
    localparam int MEM_AW = ADDR_W;
`endif

    state_t             state;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PIX_W-1:0]   mem [2**MEM_AW];
    logic               xfer;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [MEM_AW-1:0]  wr_idx;
    logic [MEM_AW-1:0]  rd_idx;

`ifdef VIDEO_DOUBLE_BUF_EN
    logic disp_bank;
    assign s.s_ready = rst && (state != FULL);
    assign wr_idx    = {~disp_bank, wr_ptr};
    assign rd_idx    = {disp_bank, rd_addr};
`else
    logic unused_sync;
    assign unused_sync = frame_sync;
    assign s.s_ready   = rst;
    assign wr_idx      = wr_ptr;
    assign rd_idx      = rd_addr;
`endif

    assign xfer   = s.s_valid && s.s_ready;
    // A start-of-frame always lands at address 0, whether it opens a frame or restarts one.
    assign wr_en  = xfer && (s.s_sof || state == WRITE);
    assign wr_ptr = s.s_sof ? '0 : wr_addr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= s.s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= WAIT_SOF;
            wr_addr     <= '0;
            frame_ready <= 1'b0;
            sof_err     <= 1'b0;
            rd_data     <= '0;
`ifdef VIDEO_DOUBLE_BUF_EN
            disp_bank   <= 1'b0;
`endif
        end else begin
            rd_data <= ({1'b0, rd_addr} >= NPIX_W) ? '0 : mem[rd_idx];
`ifndef VIDEO_DOUBLE_BUF_EN
            frame_ready <= 1'b0;
`endif
            case (state)
                WAIT_SOF: if (xfer && s.s_sof) begin
                    wr_addr <= ADDR_W'(1);
                    state   <= WRITE;
                end
                WRITE: if (xfer) begin
                    if (s.s_sof) begin
                        sof_err <= 1'b1;
                        wr_addr <= ADDR_W'(1);
                    end else if (wr_addr == LAST_ADDR) begin
                        wr_addr     <= '0;
                        frame_ready <= 1'b1;
`ifdef VIDEO_DOUBLE_BUF_EN
                        state       <= FULL;
`else
                        state       <= WAIT_SOF;
`endif
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
`ifdef VIDEO_DOUBLE_BUF_EN
                // A sync in the same cycle as the last pixel sees WRITE, so it waits for the next one.
                FULL: if (frame_sync) begin
                    disp_bank   <= ~disp_bank;
                    frame_ready <= 1'b0;
                    state       <= WAIT_SOF;
                end
`endif
                default: state <= WAIT_SOF;
            endcase
        end
    end
endmodule

// File: tb/tb_video_frame_loader.sv
// Directed bench for video_frame_loader: 4x2 main instance plus a 3x2 instance for out-of-range reads.
module tb_video_frame_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_addr, rd_addr2;
    logic [11:0] rd_data, rd_data2;
    logic        frame_sync, frame_ready, sof_err;
    logic        frame_sync2, frame_ready2, sof_err2;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    video_frame_loader_if #(.PIX_W(12)) sif ();
    video_frame_loader_if #(.PIX_W(12)) sif2 ();

    video_frame_loader #(.H_RES(4), .V_RES(2), .PIX_W(12), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .s(sif.slave), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_sync(frame_sync), .frame_ready(frame_ready), .sof_err(sof_err));

    video_frame_loader #(.H_RES(3), .V_RES(2), .PIX_W(12), .ADDR_W(3)) dut2 (
        .clk(clk), .rst(rst), .s(sif2.slave), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .frame_sync(frame_sync2), .frame_ready(frame_ready2), .sof_err(sof_err2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] d, input logic sof);
        sif.s_valid = 1'b1; sif.s_data = d; sif.s_sof = sof;
        tick();
        sif.s_valid = 1'b0; sif.s_sof = 1'b0;
    endtask

    task automatic push2(input logic [11:0] d, input logic sof);
        sif2.s_valid = 1'b1; sif2.s_data = d; sif2.s_sof = sof;
        tick();
        sif2.s_valid = 1'b0; sif2.s_sof = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_addr = a;
        tick();
    endtask

    task automatic sync_pulse();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++; if (sif.s_ready !== 1'b0) begin errs++; $display("FAIL reset_s_ready: got %b exp 0", sif.s_ready); end
        checks++; if (rd_data !== 12'h000) begin errs++; $display("FAIL reset_rd_data: got %h exp 000", rd_data); end
        checks++; if (frame_ready !== 1'b0) begin errs++; $display("FAIL reset_frame_ready: got %b exp 0", frame_ready); end
        checks++; if (sof_err !== 1'b0) begin errs++; $display("FAIL reset_sof_err: got %b exp 0", sof_err); end
        rst = 1'b1;
        tick();
        checks++; if (sif.s_ready !== 1'b1) begin errs++; $display("FAIL post_reset_s_ready: got %b exp 1", sif.s_ready); end
    endtask

    task automatic test_out_of_range();
        push2(12'h801, 1'b1);
        for (int i = 1; i < 6; i++) push2(12'h801 + 12'(i), 1'b0);
        checks++; if (frame_ready2 !== 1'b1) begin errs++; $display("FAIL oor_frame_ready: got %b exp 1", frame_ready2); end
        frame_sync2 = 1'b1; tick(); frame_sync2 = 1'b0;
        rd_addr2 = 3'd5; tick();
        checks++; if (rd_data2 !== 12'h806) begin errs++; $display("FAIL oor_addr5: got %h exp 806", rd_data2); end
        rd_addr2 = 3'd6; tick();
        checks++; if (rd_data2 !== 12'h000) begin errs++; $display("FAIL oor_addr6: got %h exp 000", rd_data2); end
        rd_addr2 = 3'd7; tick();
        checks++; if (rd_data2 !== 12'h000) begin errs++; $display("FAIL oor_addr7: got %h exp 000", rd_data2); end
    endtask

`ifdef VIDEO_DOUBLE_BUF_EN
    task automatic test_frame();
        push(12'h101, 1'b1);
        for (int i = 1; i < 8; i++) push(12'h101 + 12'(i), 1'b0);
        checks++; if (frame_ready !== 1'b1) begin errs++; $display("FAIL frame_ready_full: got %b exp 1", frame_ready); end
        checks++; if (sif.s_ready !== 1'b0) begin errs++; $display("FAIL s_ready_full: got %b exp 0", sif.s_ready); end
        rd(3'd0);
        checks++; if (rd_data === 12'h101) begin errs++; $display("FAIL early_visible: got %h exp not 101", rd_data); end
        push(12'h5AA, 1'b1);
        checks++; if (sof_err !== 1'b0) begin errs++; $display("FAIL backpressure_sof: got %b exp 0", sof_err); end
    endtask

    task automatic test_swap();
        rd_addr = 3'd0;
        sync_pulse();
        checks++; if (rd_data === 12'h101) begin errs++; $display("FAIL swap_same_edge: got %h exp old bank", rd_data); end
        checks++; if (frame_ready !== 1'b0) begin errs++; $display("FAIL swap_frame_ready: got %b exp 0", frame_ready); end
        checks++; if (sif.s_ready !== 1'b1) begin errs++; $display("FAIL swap_s_ready: got %b exp 1", sif.s_ready); end
        for (int i = 0; i < 8; i++) begin
            logic [11:0] exp_v;
            exp_v = 12'h101 + 12'(i);
            rd(3'(i));
            checks++; if (rd_data !== exp_v) begin errs++; $display("FAIL swap_rd%0d: got %h exp %h", i, rd_data, exp_v); end
        end
    endtask

    task automatic test_sof_err();
        push(12'h201, 1'b1); push(12'h202, 1'b0); push(12'h203, 1'b0);
        checks++; if (sof_err !== 1'b0) begin errs++; $display("FAIL sof_err_early: got %b exp 0", sof_err); end
        push(12'h1FF, 1'b1);
        checks++; if (sof_err !== 1'b1) begin errs++; $display("FAIL sof_err_set: got %b exp 1", sof_err); end
        for (int i = 1; i < 8; i++) push(12'h301 + 12'(i), 1'b0);
        checks++; if (frame_ready !== 1'b1) begin errs++; $display("FAIL restart_frame_ready: got %b exp 1", frame_ready); end
        rd(3'd0);
        checks++; if (rd_data !== 12'h101) begin errs++; $display("FAIL restart_pre_swap: got %h exp 101", rd_data); end
        sync_pulse();
        rd(3'd0);
        checks++; if (rd_data !== 12'h1FF) begin errs++; $display("FAIL restart_addr0: got %h exp 1FF", rd_data); end
        rd(3'd1);
        checks++; if (rd_data !== 12'h302) begin errs++; $display("FAIL restart_addr1: got %h exp 302", rd_data); end
        rd(3'd7);
        checks++; if (rd_data !== 12'h308) begin errs++; $display("FAIL restart_addr7: got %h exp 308", rd_data); end
    endtask

    task automatic test_sync_timing();
        sync_pulse();
        rd(3'd0);
        checks++; if (rd_data !== 12'h1FF) begin errs++; $display("FAIL idle_sync_swapped: got %h exp 1FF", rd_data); end
        push(12'h401, 1'b1);
        for (int i = 1; i < 7; i++) push(12'h401 + 12'(i), 1'b0);
        frame_sync = 1'b1;
        push(12'h408, 1'b0);
        frame_sync = 1'b0;
        checks++; if (frame_ready !== 1'b1) begin errs++; $display("FAIL last_sync_frame_ready: got %b exp 1", frame_ready); end
        rd(3'd0);
        checks++; if (rd_data !== 12'h1FF) begin errs++; $display("FAIL last_sync_swapped: got %h exp 1FF", rd_data); end
        sync_pulse();
        checks++; if (frame_ready !== 1'b0) begin errs++; $display("FAIL second_sync_ready: got %b exp 0", frame_ready); end
        rd(3'd0);
        checks++; if (rd_data !== 12'h401) begin errs++; $display("FAIL second_sync_addr0: got %h exp 401", rd_data); end
        rd(3'd7);
        checks++; if (rd_data !== 12'h408) begin errs++; $display("FAIL second_sync_addr7: got %h exp 408", rd_data); end
    endtask

    task automatic test_reset_mid();
        push(12'h601, 1'b1); push(12'h602, 1'b0);
        rst = 1'b0; tick();
        checks++; if (sof_err !== 1'b0) begin errs++; $display("FAIL mid_reset_sof_err: got %b exp 0", sof_err); end
        rst = 1'b1;
        rd(3'd2);
        checks++; if (rd_data !== 12'h303) begin errs++; $display("FAIL mid_reset_bank0: got %h exp 303", rd_data); end
        push(12'h7AA, 1'b0);
        push(12'h701, 1'b1);
        for (int i = 1; i < 7; i++) push(12'h701 + 12'(i), 1'b0);
        checks++; if (frame_ready !== 1'b0) begin errs++; $display("FAIL mid_reset_early_ready: got %b exp 0", frame_ready); end
        push(12'h708, 1'b0);
        checks++; if (frame_ready !== 1'b1) begin errs++; $display("FAIL mid_reset_ready: got %b exp 1", frame_ready); end
        sync_pulse();
        rd(3'd0);
        checks++; if (rd_data !== 12'h701) begin errs++; $display("FAIL mid_reset_addr0: got %h exp 701", rd_data); end
        rd(3'd7);
        checks++; if (rd_data !== 12'h708) begin errs++; $display("FAIL mid_reset_addr7: got %h exp 708", rd_data); end
    endtask
`else
    task automatic test_frame();
        push(12'h101, 1'b1);
        for (int i = 1; i < 7; i++) push(12'h101 + 12'(i), 1'b0);
        checks++; if (frame_ready !== 1'b0) begin errs++; $display("FAIL single_early_ready: got %b exp 0", frame_ready); end
        push(12'h108, 1'b0);
        checks++; if (frame_ready !== 1'b1) begin errs++; $display("FAIL single_ready_pulse: got %b exp 1", frame_ready); end
        checks++; if (sif.s_ready !== 1'b1) begin errs++; $display("FAIL single_s_ready: got %b exp 1", sif.s_ready); end
        tick();
        checks++; if (frame_ready !== 1'b0) begin errs++; $display("FAIL single_ready_clear: got %b exp 0", frame_ready); end
        for (int i = 0; i < 8; i++) begin
            logic [11:0] exp_v;
            exp_v = 12'h101 + 12'(i);
            rd(3'(i));
            checks++; if (rd_data !== exp_v) begin errs++; $display("FAIL single_rd%0d: got %h exp %h", i, rd_data, exp_v); end
        end
        sync_pulse();
        rd(3'd0);
        checks++; if (rd_data !== 12'h101) begin errs++; $display("FAIL single_sync_effect: got %h exp 101", rd_data); end
    endtask

    task automatic test_sof_err();
        push(12'h201, 1'b1); push(12'h202, 1'b0); push(12'h203, 1'b0);
        checks++; if (sof_err !== 1'b0) begin errs++; $display("FAIL single_sof_err_early: got %b exp 0", sof_err); end
        push(12'h1FF, 1'b1);
        checks++; if (sof_err !== 1'b1) begin errs++; $display("FAIL single_sof_err_set: got %b exp 1", sof_err); end
        rd(3'd0);
        checks++; if (rd_data !== 12'h1FF) begin errs++; $display("FAIL single_restart_addr0: got %h exp 1FF", rd_data); end
        rd(3'd1);
        checks++; if (rd_data !== 12'h202) begin errs++; $display("FAIL single_addr1_old: got %h exp 202", rd_data); end
        push(12'h302, 1'b0);
        rd(3'd1);
        checks++; if (rd_data !== 12'h302) begin errs++; $display("FAIL single_addr1_new: got %h exp 302", rd_data); end
        for (int i = 3; i < 9; i++) push(12'h300 + 12'(i), 1'b0);
        checks++; if (frame_ready !== 1'b1) begin errs++; $display("FAIL single_restart_ready: got %b exp 1", frame_ready); end
        push(12'h999, 1'b0);
        rd(3'd2);
        checks++; if (rd_data !== 12'h303) begin errs++; $display("FAIL single_discard: got %h exp 303", rd_data); end
        rd(3'd0);
        checks++; if (rd_data !== 12'h1FF) begin errs++; $display("FAIL single_discard_addr0: got %h exp 1FF", rd_data); end
    endtask

    task automatic test_reset_mid();
        push(12'h601, 1'b1); push(12'h602, 1'b0);
        rst = 1'b0; tick();
        checks++; if (sof_err !== 1'b0) begin errs++; $display("FAIL single_mid_reset_sof_err: got %b exp 0", sof_err); end
        rst = 1'b1;
        push(12'h7AA, 1'b0);
        rd(3'd0);
        checks++; if (rd_data !== 12'h601) begin errs++; $display("FAIL single_mid_reset_addr0: got %h exp 601", rd_data); end
        rd(3'd1);
        checks++; if (rd_data !== 12'h602) begin errs++; $display("FAIL single_mid_reset_addr1: got %h exp 602", rd_data); end
        push(12'h701, 1'b1);
        rd(3'd0);
        checks++; if (rd_data !== 12'h701) begin errs++; $display("FAIL single_new_frame: got %h exp 701", rd_data); end
    endtask
`endif

    initial begin
        rst = 1'b0; rd_addr = '0; rd_addr2 = '0; frame_sync = 1'b0; frame_sync2 = 1'b0;
        sif.s_valid = 1'b0; sif.s_data = '0; sif.s_sof = 1'b0;
        sif2.s_valid = 1'b0; sif2.s_data = '0; sif2.s_sof = 1'b0;
        test_reset();
        test_frame();
`ifdef VIDEO_DOUBLE_BUF_EN
        test_swap();
        test_sof_err();
        test_sync_timing();
`else
        test_sof_err();
`endif
        test_reset_mid();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
